// File: rtl/multicycle_control_if.sv
// Bundle of fetch, decoder, data-memory and status signals between the LEGv8 multi-cycle
// sequencer (master) and its surrounding datapath/memories (slave).
interface multicycle_control_if #(
    parameter int unsigned PC_W = 64
);
    logic            run;
    logic            imem_req;
    logic            imem_ready;
    logic [31:0]     instr_in;
    logic [PC_W-1:0] pc;
    logic [31:0]     ir_out;
    logic            dec_ubranch;
    logic            dec_branch;
    logic            dec_memread;
    logic            dec_memwrite;
    logic            dec_regwrite;
    logic [31:0]     dec_imm;
    logic            alu_zero;
    logic            dmem_req;
    logic            dmem_we;
    logic            dmem_ready;
    logic            rf_we;
    logic            retired;
    logic [2:0]      state;
    logic            timeout_err;

    modport master (
        input  run, imem_ready, instr_in, dec_ubranch, dec_branch, dec_memread, dec_memwrite,
               dec_regwrite, dec_imm, alu_zero, dmem_ready,
        output imem_req, pc, ir_out, dmem_req, dmem_we, rf_we, retired, state, timeout_err
    );

    modport slave (
        output run, imem_ready, instr_in, dec_ubranch, dec_branch, dec_memread, dec_memwrite,
               dec_regwrite, dec_imm, alu_zero, dmem_ready,
        input  imem_req, pc, ir_out, dmem_req, dmem_we, rf_we, retired, state, timeout_err
    );
endinterface

// File: rtl/multicycle_control.sv
// LEGv8 multi-cycle sequencer: owns PC and IR, steps each instruction through
// FETCH/DECODE/EXEC/MEM/WB with req/ready memory handshakes and a wait-timeout trap.
module multicycle_control #(
    parameter int unsigned     PC_W        = 64,
    parameter logic [PC_W-1:0] RESET_PC    = '0,
    parameter int unsigned     MEM_TIMEOUT = 16
) (
    input logic                  clk_i,
    input logic                  rst_i,
    multicycle_control_if.master bus_io
);
    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StFetch  = 3'd1,
        StDecode = 3'd2,
        StExec   = 3'd3,
        StMem    = 3'd4,
        StWb     = 3'd5,
        StErr    = 3'd6
    } state_e;

    localparam int unsigned CntW = $clog2(MEM_TIMEOUT + 2);

    state_e          state_q;
    logic [PC_W-1:0] pc_q;
    logic [PC_W-1:0] npc_q;
    logic [31:0]     ir_q;
    logic [CntW-1:0] wait_q;
    logic            retired_q;
    logic            terr_q;

    logic            taken;
    logic [PC_W-1:0] imm_off;
    logic [PC_W-1:0] npc_calc;
    logic            wait_hit;

    // ir_q[24] distinguishes CBNZ (1) from CBZ (0).
    assign taken    = bus_io.dec_ubranch | (bus_io.dec_branch & (bus_io.alu_zero ^ ir_q[24]));
    assign imm_off  = PC_W'($signed(bus_io.dec_imm)) << 2;
    assign npc_calc = taken ? (pc_q + imm_off) : (pc_q + PC_W'(4));
    assign wait_hit = (MEM_TIMEOUT != 0) && (wait_q == CntW'(MEM_TIMEOUT));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= StIdle;
            pc_q      <= RESET_PC;
            npc_q     <= '0;
            ir_q      <= '0;
            wait_q    <= '0;
            retired_q <= 1'b0;
            terr_q    <= 1'b0;
        end else begin
            retired_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (bus_io.run) state_q <= StFetch;
                end
                StFetch: begin
                    if (bus_io.imem_ready) begin
                        ir_q    <= bus_io.instr_in;
                        wait_q  <= '0;
                        state_q <= StDecode;
                    end else if (wait_hit) begin
                        terr_q  <= 1'b1;
                        state_q <= StErr;
                    end else begin
                        wait_q <= wait_q + 1'b1;
                    end
                end
                StDecode: state_q <= StExec;
                StExec: begin
                    npc_q <= npc_calc;
                    if (bus_io.dec_memread || bus_io.dec_memwrite) begin
                        state_q <= StMem;
                    end else if (bus_io.dec_regwrite) begin
                        state_q <= StWb;
                    end else begin
                        pc_q      <= npc_calc;
                        retired_q <= 1'b1;
                        state_q   <= bus_io.run ? StFetch : StIdle;
                    end
                end
                StMem: begin
                    if (bus_io.dmem_ready) begin
                        wait_q <= '0;
                        if (bus_io.dec_memread) begin
                            state_q <= StWb;
                        end else begin
                            pc_q      <= npc_q;
                            retired_q <= 1'b1;
                            state_q   <= bus_io.run ? StFetch : StIdle;
                        end
                    end else if (wait_hit) begin
                        terr_q  <= 1'b1;
                        state_q <= StErr;
                    end else begin
                        wait_q <= wait_q + 1'b1;
                    end
                end
                StWb: begin
                    pc_q      <= npc_q;
                    retired_q <= 1'b1;
                    state_q   <= bus_io.run ? StFetch : StIdle;
                end
                StErr: state_q <= StErr;
                default: state_q <= StErr;
            endcase
        end
    end

    assign bus_io.imem_req    = (state_q == StFetch);
    assign bus_io.dmem_req    = (state_q == StMem);
    assign bus_io.dmem_we     = (state_q == StMem) & bus_io.dec_memwrite;
    assign bus_io.rf_we       = (state_q == StWb);
    assign bus_io.pc          = pc_q;
    assign bus_io.ir_out      = ir_q;
    assign bus_io.retired     = retired_q;
    assign bus_io.state       = state_q;
    assign bus_io.timeout_err = terr_q;
endmodule
